// File: rtl/pcie_req_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_pkg / pcie_req_initiator_if
//  Description : TLP type encoding shared by both ends of the link, and the
//                bundle of client, request, completion and response signals
//                seen by the requester engine.
//                master modport : the requester engine (pcie_req_initiator)
//                slave  modport : its environment (client plus completer)
//                Ports grouped here:
//                  cmd_*  client command channel (valid/ready)
//                  req_*  MRd/MWr request channel (valid/ready)
//                  cpl_*  completion channel (valid/ready)
//                  rsp_*  client read-response channel (valid/ready)
//                  outstanding, err_unexp_cpl  status
//  Revision    : 1.0  initial release
// ============================================================================
package pcie_pkg;
  // Fmt/Type byte of a 3DW header. MRd encodes as zero, so a cleared
  // request register reads as an all-zero payload.
  typedef enum logic [7:0] {
    TLP_MRd = 8'h00,
    TLP_MWr = 8'h40
  } tlp_type_e;
endpackage

interface pcie_req_initiator_if
  import pcie_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_TAGS = 4
);
  localparam int C_CNT_W = $clog2(NUM_TAGS + 1);

  // client command
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  // request channel
  logic              req_valid;
  logic              req_ready;
  tlp_type_e         req_type;
  logic [7:0]        req_tag;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  // completion channel
  logic              cpl_valid;
  logic              cpl_ready;
  logic [2:0]        cpl_status;
  logic [7:0]        cpl_tag;
  logic [DATA_W-1:0] cpl_data;
  // client response
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_tag;
  logic [DATA_W-1:0] rsp_data;
  logic [2:0]        rsp_status;
  // status
  logic [C_CNT_W-1:0] outstanding;
  logic               err_unexp_cpl;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data,
    output cmd_ready,
    output req_valid, req_type, req_tag, req_addr, req_data,
    input  req_ready,
    input  cpl_valid, cpl_status, cpl_tag, cpl_data,
    output cpl_ready,
    output rsp_valid, rsp_tag, rsp_data, rsp_status,
    input  rsp_ready,
    output outstanding, err_unexp_cpl
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_data,
    input  cmd_ready,
    input  req_valid, req_type, req_tag, req_addr, req_data,
    output req_ready,
    output cpl_valid, cpl_status, cpl_tag, cpl_data,
    input  cpl_ready,
    input  rsp_valid, rsp_tag, rsp_data, rsp_status,
    output rsp_ready,
    input  outstanding, err_unexp_cpl
  );
endinterface
`default_nettype wire

// File: rtl/pcie_req_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_req_initiator
//  Description : Requester engine for the single-DW request/completion link.
//                Turns client read/write commands into MRd/MWr requests,
//                allocates a tag per read, matches completions to tags and
//                returns read data (or a timeout status) to the client.
//                Ports:
//                  clk, rst  clock and asynchronous active-high reset
//                  bus       pcie_req_initiator_if.master (cmd/req/cpl/rsp
//                            channels, outstanding count, drop pulse)
//  Revision    : 1.0  initial release
// ============================================================================
module pcie_req_initiator
  import pcie_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_TAGS = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  pcie_req_initiator_if.master bus
);

  localparam int         C_TAG_W          = $clog2(NUM_TAGS);
  localparam int         C_AGE_W          = $clog2(TIMEOUT + 1);
  localparam int         C_CNT_W          = $clog2(NUM_TAGS + 1);
  localparam logic [2:0] C_STATUS_TIMEOUT = 3'b111;

  // request output register
  logic              req_valid_q;
  tlp_type_e         req_type_q;
  logic [7:0]        req_tag_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;

  // response output register
  logic              rsp_valid_q;
  logic [7:0]        rsp_tag_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [2:0]        rsp_status_q;

  // tag table
  logic [NUM_TAGS-1:0] tag_busy_q, tag_busy_d;
  logic [C_AGE_W-1:0]  age_q [NUM_TAGS];
  logic [C_CNT_W-1:0]  outstanding_q, outstanding_d;
  logic                err_unexp_q;

  // combinational helpers
  logic               w_free_exists;
  logic [C_TAG_W-1:0] w_free_idx;
  logic               w_exp_any;
  logic [C_TAG_W-1:0] w_exp_idx;
  logic               w_cmd_ready;
  logic               w_cmd_acc;
  logic               w_alloc;
  logic               w_cpl_ready;
  logic               w_cpl_acc;
  logic               w_cpl_in_range;
  logic [C_TAG_W-1:0] w_cpl_idx;
  logic               w_cpl_hit;
  logic               w_to_fire;
  logic [NUM_TAGS-1:0] w_set_vec;
  logic [NUM_TAGS-1:0] w_clr_vec;

  // Lowest-index free tag and lowest-index expired tag. Scanning downwards
  // lets the last hit (the lowest index) win. Only registered busy state is
  // looked at, so a tag freed this cycle cannot be handed out until the next.
  always_comb begin
    w_free_exists = 1'b0;
    w_free_idx    = '0;
    w_exp_any     = 1'b0;
    w_exp_idx     = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!tag_busy_q[i]) begin
        w_free_exists = 1'b1;
        w_free_idx    = C_TAG_W'(i);
      end
      if (tag_busy_q[i] && (age_q[i] == C_AGE_W'(TIMEOUT))) begin
        w_exp_any = 1'b1;
        w_exp_idx = C_TAG_W'(i);
      end
    end
  end

  assign w_cmd_ready = (!req_valid_q || bus.req_ready) && (bus.cmd_write || w_free_exists);
  assign w_cmd_acc   = bus.cmd_valid && w_cmd_ready;
  assign w_alloc     = w_cmd_acc && !bus.cmd_write;

  assign w_cpl_ready    = !rsp_valid_q || bus.rsp_ready;
  assign w_cpl_acc      = bus.cpl_valid && w_cpl_ready;
  assign w_cpl_in_range = (bus.cpl_tag < 8'(NUM_TAGS));
  assign w_cpl_idx      = bus.cpl_tag[C_TAG_W-1:0];
  assign w_cpl_hit      = w_cpl_acc && w_cpl_in_range && tag_busy_q[w_cpl_idx];

  // A timeout is reported only when the response register is free and no
  // completion (matching or not) is being taken this cycle, so a completion
  // for an expired-but-unreported tag always beats its own timeout.
  assign w_to_fire = w_cpl_ready && !bus.cpl_valid && w_exp_any;

  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (w_alloc)   w_set_vec[w_free_idx] = 1'b1;
    if (w_cpl_hit) w_clr_vec[w_cpl_idx]  = 1'b1;
    if (w_to_fire) w_clr_vec[w_exp_idx]  = 1'b1;
    tag_busy_d    = (tag_busy_q & ~w_clr_vec) | w_set_vec;
    outstanding_d = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      outstanding_d = outstanding_d + C_CNT_W'(tag_busy_d[i]);
    end
  end

  // Tag table. The age counts cycles since the accept cycle, which is
  // itself age 0, so the first value visible after allocation is 1. A read
  // accepted in cycle N therefore expires in N+TIMEOUT and is reported in
  // N+TIMEOUT+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_busy_q    <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < NUM_TAGS; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      tag_busy_q    <= tag_busy_d;
      outstanding_q <= outstanding_d;
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (w_set_vec[i]) begin
          age_q[i] <= C_AGE_W'(1);
        end else if (tag_busy_q[i] && (age_q[i] != C_AGE_W'(TIMEOUT))) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  // Request register: loads on accept, otherwise holds until req_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_type_q  <= TLP_MRd;
      req_tag_q   <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
    end else if (w_cmd_acc) begin
      req_valid_q <= 1'b1;
      req_type_q  <= bus.cmd_write ? TLP_MWr : TLP_MRd;
      req_tag_q   <= bus.cmd_write ? 8'h00 : 8'(w_free_idx);
      req_addr_q  <= bus.cmd_addr;
      req_data_q  <= bus.cmd_write ? bus.cmd_data : '0;
    end else if (bus.req_ready) begin
      req_valid_q <= 1'b0;
    end
  end

  // Response register: a matching completion or a timeout report loads it;
  // otherwise it holds until the client takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else if (w_cpl_hit) begin
      rsp_valid_q  <= 1'b1;
      rsp_tag_q    <= bus.cpl_tag;
      rsp_data_q   <= bus.cpl_data;
      rsp_status_q <= bus.cpl_status;
    end else if (w_to_fire) begin
      rsp_valid_q  <= 1'b1;
      rsp_tag_q    <= 8'(w_exp_idx);
      rsp_data_q   <= '0;
      rsp_status_q <= C_STATUS_TIMEOUT;
    end else if (bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  // Any accepted completion that did not match a busy tag was dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_unexp_q <= 1'b0;
    end else begin
      err_unexp_q <= w_cpl_acc && !w_cpl_hit;
    end
  end

  assign bus.cmd_ready     = w_cmd_ready;
  assign bus.req_valid     = req_valid_q;
  assign bus.req_type      = req_type_q;
  assign bus.req_tag       = req_tag_q;
  assign bus.req_addr      = req_addr_q;
  assign bus.req_data      = req_data_q;
  assign bus.cpl_ready     = w_cpl_ready;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_tag       = rsp_tag_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_status    = rsp_status_q;
  assign bus.outstanding   = outstanding_q;
  assign bus.err_unexp_cpl = err_unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_req_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcie_req_initiator
//  Description : Directed self-checking bench for pcie_req_initiator with
//                NUM_TAGS = 4 and TIMEOUT = 16. The bench plays both the
//                client and the completer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pcie_req_initiator;
  import pcie_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int NUM_TAGS = 4;
  localparam int TIMEOUT  = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  pcie_req_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_TAGS(NUM_TAGS)) bus ();

  pcie_req_initiator #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_TAGS(NUM_TAGS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset ----------------
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_addr   = '0;
    bus.cmd_data   = '0;
    bus.req_ready  = 1'b1;
    bus.cpl_valid  = 1'b0;
    bus.cpl_status = '0;
    bus.cpl_tag    = '0;
    bus.cpl_data   = '0;
    bus.rsp_ready  = 1'b1;
    tick();
    tick();
    check("rst_req_valid",   64'(bus.req_valid),     64'd0);
    check("rst_rsp_valid",   64'(bus.rsp_valid),     64'd0);
    check("rst_err",         64'(bus.err_unexp_cpl), 64'd0);
    check("rst_outstanding", 64'(bus.outstanding),   64'd0);
    check("rst_cpl_ready",   64'(bus.cpl_ready),     64'd1);
    check("rst_cmd_ready",   64'(bus.cmd_ready),     64'd1);
    check("rst_req_addr",    64'(bus.req_addr),      64'd0);
    check("rst_rsp_data",    64'(bus.rsp_data),      64'd0);
    rst = 1'b0;
    tick();

    // ---------------- write then read ----------------
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h0000_0010;
    bus.cmd_data  = 32'h1234_5678;
    tick();
    bus.cmd_valid = 1'b0;
    check("mwr_req_valid", 64'(bus.req_valid), 64'd1);
    check("mwr_req_type",  64'(bus.req_type),  64'(TLP_MWr));
    check("mwr_req_tag",   64'(bus.req_tag),   64'h00);
    check("mwr_req_addr",  64'(bus.req_addr),  64'h10);
    check("mwr_req_data",  64'(bus.req_data),  64'h1234_5678);
    check("mwr_outst",     64'(bus.outstanding), 64'd0);
    tick();
    check("mwr_req_drop",  64'(bus.req_valid), 64'd0);

    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0010;
    bus.cmd_data  = 32'hFFFF_FFFF;
    tick();
    bus.cmd_valid = 1'b0;
    check("mrd_req_type",  64'(bus.req_type),    64'(TLP_MRd));
    check("mrd_req_tag",   64'(bus.req_tag),     64'h00);
    check("mrd_req_data",  64'(bus.req_data),    64'h0);
    check("mrd_outst",     64'(bus.outstanding), 64'd1);
    tick();
    tick();
    tick();
    // completer returns mem ^ DEAD_BEEF = 1234_5678 ^ DEAD_BEEF
    bus.cpl_valid  = 1'b1;
    bus.cpl_tag    = 8'h00;
    bus.cpl_status = 3'b000;
    bus.cpl_data   = 32'hCC99_E897;
    check("mrd_cpl_ready", 64'(bus.cpl_ready), 64'd1);
    tick();
    bus.cpl_valid = 1'b0;
    check("mrd_rsp_valid",  64'(bus.rsp_valid),   64'd1);
    check("mrd_rsp_tag",    64'(bus.rsp_tag),     64'h00);
    check("mrd_rsp_data",   64'(bus.rsp_data),    64'hCC99_E897);
    check("mrd_rsp_status", 64'(bus.rsp_status),  64'd0);
    check("mrd_outst_0",    64'(bus.outstanding), 64'd0);
    tick();
    check("mrd_rsp_done",   64'(bus.rsp_valid),   64'd0);

    // ---------------- four reads, completer stalled ----------------
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0000_0100;
    tick();
    check("rd4_tag0", 64'(bus.req_tag), 64'd0);
    bus.cmd_addr = 32'h0000_0104;
    tick();
    check("rd4_tag1", 64'(bus.req_tag), 64'd1);
    bus.cmd_addr = 32'h0000_0108;
    tick();
    check("rd4_tag2", 64'(bus.req_tag), 64'd2);
    bus.cmd_addr = 32'h0000_010C;
    tick();
    check("rd4_tag3",  64'(bus.req_tag),     64'd3);
    check("rd4_addr3", 64'(bus.req_addr),    64'h10C);
    check("rd4_outst", 64'(bus.outstanding), 64'd4);
    bus.cmd_addr = 32'h0000_0110;
    #1;
    check("rd5_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    tick();
    bus.cmd_valid = 1'b0;
    check("rd5_outst", 64'(bus.outstanding), 64'd4);

    // ---------------- out-of-order completions 2,0,3,1 ----------------
    bus.cpl_valid = 1'b1;
    bus.cpl_tag   = 8'd2;
    bus.cpl_data  = 32'hA000_0002;
    tick();
    check("ooo_v2",   64'(bus.rsp_valid), 64'd1);
    check("ooo_t2",   64'(bus.rsp_tag),   64'd2);
    check("ooo_d2",   64'(bus.rsp_data),  64'hA000_0002);
    bus.cpl_tag  = 8'd0;
    bus.cpl_data = 32'hA000_0000;
    tick();
    check("ooo_t0",   64'(bus.rsp_tag),   64'd0);
    check("ooo_d0",   64'(bus.rsp_data),  64'hA000_0000);
    bus.cpl_tag  = 8'd3;
    bus.cpl_data = 32'hA000_0003;
    tick();
    check("ooo_t3",   64'(bus.rsp_tag),   64'd3);
    check("ooo_d3",   64'(bus.rsp_data),  64'hA000_0003);
    bus.cpl_tag  = 8'd1;
    bus.cpl_data = 32'hA000_0001;
    tick();
    bus.cpl_valid = 1'b0;
    check("ooo_v1",    64'(bus.rsp_valid),   64'd1);
    check("ooo_t1",    64'(bus.rsp_tag),     64'd1);
    check("ooo_d1",    64'(bus.rsp_data),    64'hA000_0001);
    check("ooo_outst", 64'(bus.outstanding), 64'd0);
    check("ooo_noerr", 64'(bus.err_unexp_cpl), 64'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h0000_0200;
    tick();
    bus.cmd_valid = 1'b0;
    check("reuse_tag0", 64'(bus.req_tag), 64'd0);
    bus.cpl_valid = 1'b1;
    bus.cpl_tag   = 8'd0;
    bus.cpl_data  = 32'h5555_0000;
    tick();
    bus.cpl_valid = 1'b0;
    check("reuse_rsp", 64'(bus.rsp_data), 64'h5555_0000);
    tick();

    // ---------------- timeout ----------------
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h0000_0300;
    tick();                       // accept cycle N -> now in N+1
    bus.cmd_valid = 1'b0;
    check("to_tag", 64'(bus.req_tag), 64'd0);
    repeat (15) tick();           // now in N+16
    check("to_not_early", 64'(bus.rsp_valid),   64'd0);
    check("to_outst_1",   64'(bus.outstanding), 64'd1);
    tick();                       // N+17
    check("to_rsp_valid",  64'(bus.rsp_valid),   64'd1);
    check("to_rsp_status", 64'(bus.rsp_status),  64'h7);
    check("to_rsp_data",   64'(bus.rsp_data),    64'h0);
    check("to_rsp_tag",    64'(bus.rsp_tag),     64'd0);
    check("to_outst_0",    64'(bus.outstanding), 64'd0);
    bus.cpl_valid = 1'b1;
    bus.cpl_tag   = 8'd0;
    bus.cpl_data  = 32'hBAD0_BAD0;
    tick();
    bus.cpl_valid = 1'b0;
    check("late_err",   64'(bus.err_unexp_cpl), 64'd1);
    check("late_norsp", 64'(bus.rsp_valid),     64'd0);
    tick();
    check("late_err_pulse", 64'(bus.err_unexp_cpl), 64'd0);

    // ---------------- response back-pressure ----------------
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h0000_0400;
    tick();
    bus.cmd_addr  = 32'h0000_0404;
    tick();
    bus.cmd_valid = 1'b0;
    check("bp_outst", 64'(bus.outstanding), 64'd2);
    bus.rsp_ready = 1'b0;
    bus.cpl_valid = 1'b1;
    bus.cpl_tag   = 8'd0;
    bus.cpl_data  = 32'hD000_0000;
    tick();
    bus.cpl_tag  = 8'd1;
    bus.cpl_data = 32'hD000_0001;
    #1;
    check("bp_cpl_ready_0", 64'(bus.cpl_ready), 64'd0);
    check("bp_first_tag",   64'(bus.rsp_tag),   64'd0);
    tick();
    check("bp_hold_tag",    64'(bus.rsp_tag),   64'd0);
    check("bp_hold_data",   64'(bus.rsp_data),  64'hD000_0000);
    check("bp_outst_1",     64'(bus.outstanding), 64'd1);
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_cpl_ready_1", 64'(bus.cpl_ready), 64'd1);
    tick();
    bus.cpl_valid = 1'b0;
    check("bp_second_v",    64'(bus.rsp_valid), 64'd1);
    check("bp_second_tag",  64'(bus.rsp_tag),   64'd1);
    check("bp_second_data", 64'(bus.rsp_data),  64'hD000_0001);
    check("bp_noerr",       64'(bus.err_unexp_cpl), 64'd0);
    tick();
    check("bp_done",  64'(bus.rsp_valid),   64'd0);
    check("bp_outst", 64'(bus.outstanding), 64'd0);

    // ---------------- reset mid-operation ----------------
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h0000_0500;
    tick();
    tick();
    tick();
    bus.cmd_valid = 1'b0;
    bus.req_ready = 1'b0;
    check("mr_tag2",      64'(bus.req_tag),     64'd2);
    check("mr_outst3",    64'(bus.outstanding), 64'd3);
    tick();
    check("mr_req_held",  64'(bus.req_valid),   64'd1);
    rst = 1'b1;
    #1;
    check("mr_async_req_valid", 64'(bus.req_valid), 64'd0);
    tick();
    check("mr_req_valid", 64'(bus.req_valid),   64'd0);
    check("mr_req_tag",   64'(bus.req_tag),     64'd0);
    check("mr_req_addr",  64'(bus.req_addr),    64'd0);
    check("mr_outst",     64'(bus.outstanding), 64'd0);
    check("mr_rsp_valid", 64'(bus.rsp_valid),   64'd0);
    check("mr_cpl_ready", 64'(bus.cpl_ready),   64'd1);
    rst           = 1'b0;
    bus.req_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h0000_0600;
    tick();
    bus.cmd_valid = 1'b0;
    check("post_rst_tag",   64'(bus.req_tag),     64'd0);
    check("post_rst_outst", 64'(bus.outstanding), 64'd1);
    tick();
    check("post_rst_norsp", 64'(bus.rsp_valid),   64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
